// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared select-code constants and types for the 4-to-1 steering mux
package mux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/sel_decoder_2to4.sv
// rtl/sel_decoder_2to4.sv - one-hot decode of the 2-bit select code
module sel_decoder_2to4
    import mux_pkg::*;
(
    input  sel_t       sel,
    output logic [3:0] sel_oh
);

    // Non-binary sel lands in default, giving an all-zero decode and no latch.
    always_comb begin
        sel_oh = 4'b0000;
        case (sel)
            SEL_A:   sel_oh = 4'b0001;
            SEL_B:   sel_oh = 4'b0010;
            SEL_C:   sel_oh = 4'b0100;
            SEL_D:   sel_oh = 4'b1000;
            default: sel_oh = 4'b0000;
        endcase
    end

endmodule

// File: rtl/multiplexer_2bit.sv
// rtl/multiplexer_2bit.sv - 4-to-1 AND-OR mux with combinational and registered outputs
// Optional MULTIPLEXER_2BIT_HOLD_EN adds en to gate Q_reg loading.
module multiplexer_2bit
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MULTIPLEXER_2BIT_HOLD_EN
    input  logic             en,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  sel_t             sel,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_reg,
    output logic [3:0]       sel_oh
);

    sel_decoder_2to4 u_dec (
        .sel    (sel),
        .sel_oh (sel_oh)
    );

    // AND-OR select: an unselected input is masked to zero, so it cannot leak into Q.
    always_comb begin
        Q = ({WIDTH{sel_oh[0]}} & A)
          | ({WIDTH{sel_oh[1]}} & B)
          | ({WIDTH{sel_oh[2]}} & C)
          | ({WIDTH{sel_oh[3]}} & D);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q_reg <= '0;
`ifdef MULTIPLEXER_2BIT_HOLD_EN
        end else if (en) begin
            Q_reg <= Q;
`else
        end else begin
            Q_reg <= Q;
`endif
        end
    end

endmodule

// File: tb/tb_multiplexer_2bit.sv
// tb/tb_multiplexer_2bit.sv - directed scoreboard bench for multiplexer_2bit
module tb_multiplexer_2bit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b, c, d;
    logic [1:0]   sel;
    logic [W-1:0] q, q_reg;
    logic [3:0]   sel_oh;
`ifdef MULTIPLEXER_2BIT_HOLD_EN
    logic         en = 1'b1;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    multiplexer_2bit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
`ifdef MULTIPLEXER_2BIT_HOLD_EN
        .en     (en),
`endif
        .A      (a),
        .B      (b),
        .C      (c),
        .D      (d),
        .sel    (sel),
        .Q      (q),
        .Q_reg  (q_reg),
        .sel_oh (sel_oh)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_q(input logic [1:0] s, input logic [W-1:0] va, vb, vc, vd);
        case (s)
            2'b00:   return va;
            2'b01:   return vb;
            2'b10:   return vc;
            default: return vd;
        endcase
    endfunction

    function automatic logic [3:0] model_oh(input logic [1:0] s);
        logic [3:0] one;
        one = 4'b0001;
        return one << s;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one input set, check combinational outputs, queue the expected Q_reg.
    task automatic drive(input string tag, input logic [W-1:0] va, vb, vc, vd, input logic [1:0] s);
        logic [W-1:0] e;
        a = va; b = vb; c = vc; d = vd; sel = s;
        e = model_q(s, va, vb, vc, vd);
        #1;
        check({tag, "_q"}, q, e);
        check({tag, "_oh"}, {12'd0, sel_oh}, {12'd0, model_oh(s)});
        exp_q.push_back(e);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_qreg observed=%h expected=<scoreboard empty>", tag, q_reg);
        end else begin
            check({tag, "_qreg"}, q_reg, exp_q.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1;
        a = '0; b = '0; c = '0; d = '0; sel = 2'b00;
        #2;
        check("reset_qreg", q_reg, '0);
        check("reset_q", q, '0);
        @(posedge clk);
        #1;
        check("reset_hold_qreg", q_reg, '0);

        @(negedge clk);
        rst = 1'b0;
        drive("sel_a", 16'h0001, 16'h0000, 16'h0000, 16'h0000, 2'b00); tick("sel_a");
        drive("sel_b", 16'h0000, 16'h0001, 16'h0000, 16'h0000, 2'b01); tick("sel_b");
        drive("sel_c", 16'h0000, 16'h0000, 16'h0001, 16'h0000, 2'b10); tick("sel_c");
        drive("sel_d", 16'h0000, 16'h0000, 16'h0000, 16'h0001, 2'b11); tick("sel_d");
        drive("unsel", 16'h0001, 16'h0001, 16'h0000, 16'h0000, 2'b11); tick("unsel");
        drive("all1",  16'h0001, 16'h0001, 16'h0001, 16'h0001, 2'b10); tick("all1");

        // Unselected inputs toggle while sel holds A.
        drive("tog0", 16'h5A5A, 16'h0000, 16'h0000, 16'h0000, 2'b00);
        b = 16'hFFFF; c = 16'h1357; d = 16'h8001;
        #1;
        check("tog1_q", q, 16'h5A5A);
        tick("tog");

        for (int s = 0; s < 4; s++) begin
            drive("sweep", 16'h1234, 16'hABCD, 16'h00FF, 16'hFFFF, 2'(s));
            tick("sweep");
        end

        drive("mid0", 16'h1234, 16'hABCD, 16'h00FF, 16'hFFFF, 2'b00); tick("mid0");
        drive("mid1", 16'h1234, 16'hABCD, 16'h00FF, 16'hFFFF, 2'b01);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_qreg", q_reg, '0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_hold_qreg", q_reg, '0);
        check("rst_q_valid", q, 16'hABCD);
        #2;
        rst = 1'b0;
        drive("post2", 16'h1234, 16'hABCD, 16'h00FF, 16'hFFFF, 2'b10); tick("post2");
        drive("post3", 16'h1234, 16'hABCD, 16'h00FF, 16'hFFFF, 2'b11); tick("post3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
